// File: rtl/axis_fifo_pkg.sv
// Shared constants and elaboration helpers for the AXI-Stream FIFO.
package axis_fifo_pkg;

    localparam int AXIS_FIFO_DEFAULT_DEPTH = 4;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream handshake bundle: manager drives tvalid/tdata, subordinate drives tready.
interface axis_if #(
    parameter int TDATA_WIDTH = 32
) ();

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);

endinterface

// File: rtl/axis_fifo.sv
// Registered AXI-Stream FIFO with synchronous flush; outputs depend only on stored state.
module axis_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DEPTH = AXIS_FIFO_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axis_if.s                        axis_sif,
    axis_if.m                        axis_mif,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = axis_sif.TDATA_WIDTH;
    localparam int MW = axis_mif.TDATA_WIDTH;

    if (SW == 0) begin : g_bad_width
        $fatal(1, "axis_fifo: TDATA_WIDTH must be non-zero");
    end
    if (SW != MW) begin : g_width_mismatch
        $fatal(1, "axis_fifo: upstream and downstream TDATA_WIDTH differ");
    end
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $fatal(1, "axis_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [SW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_level;
    logic          r_tready;

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_level_next;

    assign w_push = axis_sif.tvalid && r_tready;
    assign w_pop  = axis_mif.tvalid && axis_mif.tready;

    // A pop during flush still completes downstream; only the bookkeeping is discarded.
    assign w_level_next = flush ? '0 : (r_level + PW'(w_push) - PW'(w_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_tready <= 1'b0;
        end else begin
            r_level  <= w_level_next;
            r_tready <= (w_level_next != PW'(DEPTH)) && !flush;
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= axis_sif.tdata;
        end
    end

    assign axis_sif.tready = r_tready;
    assign axis_mif.tvalid = (r_level != '0);
    assign axis_mif.tdata  = r_mem[r_rd_ptr[AW-1:0]];
    assign level           = r_level;

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 Parameter DEPTH: default 4; number of storage entries, power of two, at least 2.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset: clk input 1 (all state rising-edge), rst_n input 1 (asynchronous, active-low).
REQ-003 axis_sif  modport s  axis_if  upstream subordinate port; TDATA_WIDTH taken from the interface.
REQ-004 axis_mif  modport m  axis_if  downstream manager port, intended to drive axis_skid_buffer.axis_sif.
REQ-005 flush  input  1  synchronous discard of all stored and in-flight-accepted words.
REQ-006 level  output  $clog2(DEPTH)+1  registered count of stored words.
REQ-007 Elaboration SHALL $fatal if TDATA_WIDTH is 0, if the two interfaces' TDATA_WIDTH values differ, or if DEPTH is not a power of two or is below 2.

Function
REQ-008 Push SHALL be axis_sif.tvalid && axis_sif.tready; pop SHALL be axis_mif.tvalid && axis_mif.tready.
REQ-009 Storage SHALL be a DEPTH-entry array with read and write pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
REQ-010 Empty SHALL be pointers equal; full SHALL be low bits equal with wrap bits different.
REQ-011 axis_mif.tvalid SHALL equal level != 0, derived from registered state only, with no combinational path from axis_sif.
REQ-012 axis_mif.tdata SHALL equal mem[rd_ptr low bits] and SHALL hold stable while tvalid && !tready.
REQ-013 axis_sif.tready SHALL be a register loaded each cycle with (next level != DEPTH) && !flush.
- No combinational path from axis_mif.tready.
REQ-014 A word pushed at edge N SHALL be visible on axis_mif at cycle N+1; there is no same-cycle pass-through when empty.
REQ-015 Push at edge: mem[wr_ptr] <= axis_sif.tdata and wr_ptr increments mod 2*DEPTH.
REQ-016 Pop at edge: rd_ptr increments mod 2*DEPTH.
REQ-017 Simultaneous push and pop SHALL leave level unchanged; data order is strict FIFO.
REQ-018 When full, tready is 0, so no push occurs even if pop occurs that cycle; tready returns to 1 on the following edge.
REQ-019 Pointer wrap from 2*DEPTH-1 to 0 SHALL be seamless: no lost or duplicated word.
REQ-020 Flush asserted at an edge SHALL set rd_ptr = wr_ptr = 0 and level = 0.
- A push in the same cycle is discarded.
- A pop in the same cycle still counts as a completed handshake for downstream.
- Next cycle: tvalid = 0 and tready = 0; tready = 1 one cycle later.
REQ-021 Flush while empty SHALL be harmless; flush held for multiple cycles SHALL keep the FIFO empty and tready low.
REQ-022 level SHALL update every edge as level + push - pop, or 0 on flush.

Reset
REQ-023 rst_n low SHALL asynchronously clear rd_ptr, wr_ptr and level to 0, and axis_sif.tready to 0.
- Consequently axis_mif.tvalid = 0 and level = 0.
REQ-024 Storage array contents SHALL NOT be reset; tdata is don't-care while tvalid = 0.
REQ-025 axis_sif.tready SHALL rise at the first clock edge after rst_n deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all contents, identical to the power-on state.

Structure
REQ-027 No new package typedefs are needed: the width comes from axis_if; pointer width is a local parameter.
REQ-028 The block is a single module with no sub-module; the storage array is inferred as distributed RAM or registers.
REQ-029 Implementation size SHALL be roughly 120-200 lines.

Verification
REQ-030 DEPTH=4, width 32: push 0xA0..0xA3 with mif.tready = 0 -> level = 4, sif.tready = 0 at the cycle after the 4th push, mif.tdata = 0xA0.
REQ-031 From full, hold mif.tready = 1 for 4 cycles -> outputs 0xA0, 0xA1, 0xA2, 0xA3 in order; tvalid = 0 after; level = 0.
REQ-032 Continuous push and pop (both ready) for 20 words 0..19 -> output sequence 0..19 with no gaps after the first-word latency of 1 cycle; pointers wrap at least twice.
REQ-033 Store 3 words, assert flush with a simultaneous sif push of 0xFF -> next cycle level = 0, tvalid = 0, tready = 0; 0xFF is never output; tready = 1 the cycle after.
REQ-034 Assert rst_n = 0 mid-burst with level = 2 -> immediately tvalid = 0, tready = 0, level = 0; after release, first new push 0x55 is output first.
REQ-035 Randomized valid/ready backpressure over 1000 words against a scoreboard -> zero mismatches.
- The AXIS rule holds: tdata stable while tvalid && !tready.
